// File: rtl/led_fade_pwm_if.sv
// led_fade_pwm_if: level request into the fader, PWM pin drive and ramp status out.
interface led_fade_pwm_if #(parameter int PWM_BITS = 8);
  logic level_i;
  logic led_o;
  logic [PWM_BITS-1:0] duty_o;
  logic busy_o;
  modport master (output level_i, input led_o, duty_o, busy_o);
  modport slave (input level_i, output led_o, duty_o, busy_o);
endinterface

// File: rtl/led_fade_pwm.sv
// led_fade_pwm: turns a binary LED level into a PWM pin drive whose duty ramps
// linearly between off and full-on, so every toggle becomes a smooth fade.
module led_fade_pwm #(
  parameter int CLK_HZ = 25_000_000,
  parameter int FADE_MS = 500,
  parameter int PWM_BITS = 8,
  parameter bit ACTIVE_LOW = 1
) (
  input logic clk_i,
  input logic rst_i,
  led_fade_pwm_if.slave bus
);
  localparam longint DMAX = (longint'(1) << PWM_BITS) - 1;
  localparam longint STEP_RAW = longint'(CLK_HZ) * longint'(FADE_MS) / 1000 / DMAX;
  localparam longint STEP_CYCLES = STEP_RAW < 1 ? 1 : STEP_RAW;
  localparam int PW = STEP_CYCLES > 1 ? $clog2(STEP_CYCLES) : 1;
  localparam logic [PW-1:0] TC = PW'(STEP_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] FULL = '1;
  typedef enum logic [1:0] {IDLE_LOW, RISE, IDLE_HIGH, FALL} state_t;
  state_t state;
  logic [PWM_BITS-1:0] duty, pwm_cnt;
  logic [PW-1:0] pre;
  logic [1:0] sync;
  logic led, on, level_s;
  assign level_s = sync[1];
  assign on = duty == FULL || pwm_cnt < duty;
  // Steps saturate at the rails so a reversal right at an endpoint cannot wrap the duty.
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= IDLE_LOW;
      duty <= '0;
      pwm_cnt <= '0;
      pre <= '0;
      sync <= '0;
      led <= ACTIVE_LOW;
    end else begin
      sync <= {sync[0], bus.level_i};
      pwm_cnt <= pwm_cnt + 1'b1;
      led <= ACTIVE_LOW ? ~on : on;
      case (state)
        IDLE_LOW:
          if (level_s) begin
            state <= RISE;
            pre <= '0;
          end
        RISE:
          if (!level_s) begin
            state <= FALL;
            pre <= '0;
          end else if (pre == TC) begin
            pre <= '0;
            duty <= duty == FULL ? duty : duty + 1'b1;
            if (duty >= FULL - 1'b1) state <= IDLE_HIGH;
          end else pre <= pre + 1'b1;
        IDLE_HIGH:
          if (!level_s) begin
            state <= FALL;
            pre <= '0;
          end
        FALL:
          if (level_s) begin
            state <= RISE;
            pre <= '0;
          end else if (pre == TC) begin
            pre <= '0;
            duty <= duty == '0 ? duty : duty - 1'b1;
            if (duty <= PWM_BITS'(1)) state <= IDLE_LOW;
          end else pre <= pre + 1'b1;
        default: state <= IDLE_LOW;
      endcase
    end
  assign bus.led_o = led;
  assign bus.duty_o = duty;
  assign bus.busy_o = state == RISE || state == FALL;
endmodule

// File: tb/tb_led_fade_pwm.sv
// tb_led_fade_pwm: table vectors, corner sequences and random level traffic
// compared each cycle against a target/direction model of the fader.
module tb_led_fade_pwm;
  localparam int CLK_HZ = 1_000_000;
  localparam int FADE_MS = 1;
  localparam int PWM_BITS = 4;
  localparam bit ACTIVE_LOW = 1;
  localparam int DMAX = (1 << PWM_BITS) - 1;
  localparam int STEP = CLK_HZ / 1000 * FADE_MS / DMAX;
  logic clk = 0, rst = 1, level = 1;
  int passed = 0, total = 0;
  int m_duty, m_cnt, m_pwm, m_dir;
  bit m_move, m_led, h0, h1;
  led_fade_pwm_if #(.PWM_BITS(PWM_BITS)) bus();
  assign bus.level_i = level;
  led_fade_pwm #(.CLK_HZ(CLK_HZ), .FADE_MS(FADE_MS), .PWM_BITS(PWM_BITS), .ACTIVE_LOW(ACTIVE_LOW))
    dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic lvl;
    int cycles;
    int duty;
    logic busy;
  } vec_t;
  vec_t vecs[9];
  task automatic chk(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask
  task automatic model_reset();
    m_duty = 0; m_cnt = 0; m_pwm = 0; m_dir = 0; m_move = 0; h0 = 0; h1 = 0;
    m_led = ACTIVE_LOW;
  endtask
  // One clock edge of behaviour: the LED request seen two edges late sets a target rail,
  // the duty walks toward it one unit per STEP cycles, and a change of mind restarts timing.
  task automatic model_step();
    bit on;
    int want;
    on = (m_duty == DMAX) || (m_pwm < m_duty);
    m_led = ACTIVE_LOW ? !on : on;
    m_pwm = (m_pwm + 1) % (DMAX + 1);
    want = h1 ? 1 : -1;
    if (!m_move) begin
      if (m_duty != (h1 ? DMAX : 0)) begin m_move = 1; m_dir = want; m_cnt = 0; end
    end else if (want != m_dir) begin
      m_dir = want; m_cnt = 0;
    end else begin
      m_cnt++;
      if (m_cnt == STEP) begin
        m_cnt = 0;
        m_duty = m_duty + m_dir;
        if (m_duty > DMAX) m_duty = DMAX;
        if (m_duty < 0) m_duty = 0;
        if (m_duty == (m_dir > 0 ? DMAX : 0)) m_move = 0;
      end
    end
    h1 = h0; h0 = level;
  endtask
  task automatic tick();
    if (!rst) model_step();
    @(posedge clk);
    #1;
    if (!rst) begin
      chk("model_duty", int'(bus.duty_o), m_duty);
      chk("model_busy", int'(bus.busy_o), int'(m_move));
      chk("model_led", int'(bus.led_o), int'(m_led));
    end
  endtask
  task automatic wait_duty(int target, int budget);
    for (int i = 0; i < budget && int'(bus.duty_o) != target; i++) tick();
    chk("wait_duty", int'(bus.duty_o), target);
  endtask
  initial begin
    int zeros, maxd;
    vecs = '{'{1, 3, 0, 1}, '{1, 65, 0, 1}, '{1, 1, 1, 1}, '{1, 923, 14, 1}, '{1, 1, 15, 0},
             '{0, 2, 15, 0}, '{0, 1, 15, 1}, '{0, 66, 14, 1}, '{0, 924, 0, 0}};
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_led", int'(bus.led_o), 1);
    chk("reset_duty", int'(bus.duty_o), 0);
    chk("reset_busy", int'(bus.busy_o), 0);
    level = 0;
    rst = 0;
    for (int v = 0; v < 9; v++) begin
      level = vecs[v].lvl;
      repeat (vecs[v].cycles) tick();
      chk($sformatf("vec%0d_duty", v), int'(bus.duty_o), vecs[v].duty);
      chk($sformatf("vec%0d_busy", v), int'(bus.busy_o), int'(vecs[v].busy));
    end
    for (int i = 0; i < 32; i++) begin tick(); chk("led_off_const", int'(bus.led_o), 1); end
    level = 1;
    wait_duty(15, 1100);
    tick();
    for (int i = 0; i < 32; i++) begin tick(); chk("led_on_const", int'(bus.led_o), 0); end
    level = 0;
    wait_duty(0, 1100);
    // Freeze at duty 5 by reversing faster than one step period.
    level = 1;
    wait_duty(5, 500);
    level = 0;
    tick();
    zeros = 0;
    for (int i = 0; i < 160; i++) begin
      if (i % 30 == 29) level = ~level;
      tick();
      if (bus.led_o == 1'b0) zeros++;
    end
    chk("pwm5_zeros", zeros, 50);
    chk("pwm5_duty", int'(bus.duty_o), 5);
    level = 0;
    wait_duty(0, 1000);
    repeat (4) tick();
    level = 1;
    wait_duty(8, 700);
    level = 0;
    maxd = 8;
    repeat (3) tick();
    chk("rev_entry_duty", int'(bus.duty_o), 8);
    chk("rev_entry_busy", int'(bus.busy_o), 1);
    for (int i = 0; i < 65; i++) begin tick(); if (int'(bus.duty_o) > maxd) maxd = int'(bus.duty_o); end
    chk("rev_hold", int'(bus.duty_o), 8);
    tick();
    chk("rev_step", int'(bus.duty_o), 7);
    chk("rev_never9", maxd, 8);
    wait_duty(0, 700);
    repeat (4) tick();
    // Reversal lands on the edge where the prescaler sits at its terminal count.
    level = 1;
    repeat (132) tick();
    level = 0;
    repeat (3) tick();
    chk("simul_duty", int'(bus.duty_o), 1);
    chk("simul_busy", int'(bus.busy_o), 1);
    repeat (65) tick();
    chk("simul_hold", int'(bus.duty_o), 1);
    tick();
    chk("simul_step", int'(bus.duty_o), 0);
    chk("simul_idle", int'(bus.busy_o), 0);
    level = 1;
    wait_duty(7, 600);
    #3 rst = 1;
    #1;
    chk("async_led", int'(bus.led_o), 1);
    chk("async_duty", int'(bus.duty_o), 0);
    chk("async_busy", int'(bus.busy_o), 0);
    model_reset();
    #2 rst = 0;
    repeat (3) tick();
    chk("restart_busy", int'(bus.busy_o), 1);
    repeat (66) tick();
    chk("restart_duty", int'(bus.duty_o), 1);
    for (int s = 0; s < 40; s++) begin
      level = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 300)) tick();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/led_fade_pwm.md
# led_fade_pwm

Output stage between a level source such as the 10 s blinker and the LED pin on the iCESugar-pro. It consumes the binary LED level the blinker produces and drives the physical pin with a PWM waveform. The duty cycle ramps linearly between off and full-on, so each toggle becomes a smooth fade instead of a hard edge.

## Interface
- CLK_HZ, 25_000_000: input clock frequency in Hz.
- FADE_MS, 500: duration of one full off->on or on->off ramp, in ms.
- PWM_BITS, 8: duty/PWM counter width. DMAX = 2^PWM_BITS-1.
- ACTIVE_LOW, 1: 1 means the pin is driven low to light the LED.
- clk_i  input  1  sole clock.
- rst_i  input  1  reset, asynchronous and active-high.
- level_i  input  1  requested LED state (1 = on); may be asynchronous to clk_i.
- led_o  output  1  PWM drive to the LED pin, registered.
- duty_o  output  PWM_BITS  current duty value.
- busy_o  output  1  high while a ramp is in progress.

## Operation
- STEP_CYCLES = max(1, floor(CLK_HZ*FADE_MS/1000/DMAX)).
  - Compute in 64-bit arithmetic; 25e6*500 overflows 32 bits.
  - Prescaler width = max(1, $clog2(STEP_CYCLES)).
- level_i passes through a 2-FF synchronizer; level_s is the second stage.
- FSM states:
  - IDLE_LOW: duty 0, reset state.
  - RISE
  - IDLE_HIGH: duty DMAX.
  - FALL
- Transitions:
  - IDLE_LOW, level_s=1 -> RISE. IDLE_HIGH, level_s=0 -> FALL. Either entry clears the prescaler.
  - RISE: at prescaler terminal count (STEP_CYCLES-1), duty +1 and prescaler wraps to 0. If the new duty is DMAX -> IDLE_HIGH.
  - FALL: mirror of RISE. Duty -1; reaching 0 -> IDLE_LOW.
  - RISE with level_s=0 -> FALL; FALL with level_s=1 -> RISE. Duty is held, with no jump, and the prescaler is cleared.
  - Reversal and terminal count in the same cycle: reversal wins and no step is taken that cycle.
- Duty never wraps: it is saturated at 0 and DMAX by construction.
- PWM:
  - Free-running counter pwm_cnt, 0..DMAX, wraps to 0. It is not affected by the FSM.
  - on = (duty == DMAX) || (pwm_cnt < duty). Duty 0 gives solid off; DMAX gives solid on.
  - led_o <= ACTIVE_LOW ? ~on : on.
- busy_o = (state == RISE || state == FALL), decoded from the state register.
- duty_o = duty register.

## Timing
- Reset values:
  - state IDLE_LOW, duty 0, pwm_cnt 0, prescaler 0, sync FFs 0.
  - duty_o 0, busy_o 0.
  - led_o = ACTIVE_LOW (LED dark).
- rst_i asserted mid-ramp clears everything immediately, not on a clock edge. Release with level_i=1 starts a fresh ramp from duty 0.
- Edge latency:
  - level_i change -> level_s after 2 clk_i edges.
  - state and busy_o update on the 3rd edge.
  - First duty step occurs STEP_CYCLES edges after the state change.
- A full ramp takes DMAX*STEP_CYCLES cycles after entry. busy_o falls on the same edge that duty reaches its endpoint.
- Duty takes effect at the next pwm_cnt compare. led_o lags the compare by 1 cycle due to its register.
- PWM period is DMAX+1 cycles: 256 cycles, about 97.7 kHz, at defaults.
- A level_i pulse shorter than 2 cycles may be missed. This is acceptable because the intended source toggles in seconds.

## Test plan
Bench parameters: CLK_HZ=1_000_000, FADE_MS=1, PWM_BITS=4, ACTIVE_LOW=1. This gives DMAX=15 and STEP_CYCLES=66.
- Reset: hold rst_i with level_i=1 -> led_o=1, duty_o=0, busy_o=0. Assert rst_i asynchronously mid-ramp at duty 7 -> all outputs return to reset values before the next clock edge.
- Full rise: level_i 0->1 at cycle 0.
  - busy_o=1 from edge 3.
  - duty_o=1 at edge 69, 15 at edge 3+990=993, with busy_o=0 at that edge.
  - Afterwards led_o stays constant 0.
- Full fall from IDLE_HIGH: duty_o decrements every 66 cycles to 0. At the end led_o stays constant 1 and busy_o=0.
- PWM duty check: freeze at duty 5 (level_i=1, then reverse at the right moment) -> exactly 5 of every 16 cycles have led_o=0.
- Mid-ramp reversal: at duty 8 drop level_i -> FALL entered with duty still 8. The next step goes to 7 after 66 cycles. Duty is never 9.
- Simultaneous reversal and terminal count: align level_s change with prescaler=65 -> duty unchanged that cycle and prescaler cleared to 0.
